// File: rtl/spi_flash_defs.sv
// Shared opcodes, state encoding and pad-enable decode for the QSPI flash responder.
package spi_flash_defs;

  localparam logic [7:0] CMD_READ     = 8'h03;
  localparam logic [7:0] CMD_QREAD    = 8'hEB;
  localparam logic [7:0] CMD_RDSR     = 8'h05;
  localparam logic [1:0] CONT_PATTERN = 2'b10;

  typedef enum logic [3:0] {
    StIdle,
    StCmd,
    StSaddr,
    StQaddr,
    StQmode,
    StQdummy,
    StSdata,
    StQdata,
    StStatus,
    StIgnore
  } state_e;

  function automatic logic [3:0] oe_for_state(state_e s);
    case (s)
      StSdata, StStatus: return 4'b0010;
      StQdata:           return 4'b1111;
      default:           return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizers for SCK, CS# and IO[3:0], plus edge detect against a third
// (edge) register so that an edge is acted on 3 clocks after the pin moves.
module spi_pin_sync (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_sck,
  input  logic       i_cs_n,
  input  logic [3:0] i_io,
  output logic       o_sck_rise,
  output logic       o_sck_fall,
  output logic       o_cs_rise,
  output logic       o_cs_fall,
  output logic       o_cs_n,
  output logic [3:0] o_io
);
  logic [2:0] r_sck;
  logic [2:0] r_cs;
  logic [3:0] r_io_s1;
  logic [3:0] r_io_s2;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_sck   <= 3'b000;
      r_cs    <= 3'b111;
      r_io_s1 <= 4'h0;
      r_io_s2 <= 4'h0;
    end else begin
      r_sck   <= {r_sck[1:0], i_sck};
      r_cs    <= {r_cs[1:0], i_cs_n};
      r_io_s1 <= i_io;
      r_io_s2 <= r_io_s1;
    end
  end

  assign o_sck_rise = r_sck[1] & ~r_sck[2];
  assign o_sck_fall = ~r_sck[1] & r_sck[2];
  assign o_cs_rise  = r_cs[1] & ~r_cs[2];
  assign o_cs_fall  = ~r_cs[1] & r_cs[2];
  assign o_cs_n     = r_cs[1];
  // Data stage matches the SCK stage used for edge detect.
  assign o_io       = r_io_s2;

endmodule

// File: rtl/spi_flash_responder.sv
// QSPI flash device model: READ (0x03), quad I/O FAST READ (0xEB) with continuous mode,
// and READ STATUS (0x05), reading a synchronous byte-wide backing memory.
module spi_flash_responder
  import spi_flash_defs::*;
#(
  parameter int unsigned ADDR_BITS  = 24,
  parameter int unsigned QUAD_DUMMY = 4
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_spi_sck,
  input  logic                 i_spi_cs_n,
  input  logic [3:0]           i_io_in,
  output logic [3:0]           o_io_out,
  output logic [3:0]           o_io_oe,
  output logic                 o_mem_rden,
  output logic [ADDR_BITS-1:0] o_mem_addr,
  input  logic [7:0]           i_mem_rdata,
  output logic                 o_busy
);
  localparam logic [4:0] DUMMY_LAST = 5'(QUAD_DUMMY - 1);

  logic       w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall, w_cs_n;
  logic [3:0] w_io;

  spi_pin_sync u_pin_sync (
    .i_clock    (i_clock),
    .i_reset    (i_reset),
    .i_sck      (i_spi_sck),
    .i_cs_n     (i_spi_cs_n),
    .i_io       (i_io_in),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall),
    .o_cs_rise  (w_cs_rise),
    .o_cs_fall  (w_cs_fall),
    .o_cs_n     (w_cs_n),
    .o_io       (w_io)
  );

  state_e               r_state, w_state;
  logic [4:0]           r_cnt, w_cnt;
  logic [23:0]          r_in, w_in;
  logic [7:0]           r_out, w_out;
  logic [7:0]           r_prefetch, w_prefetch;
  logic                 r_fetch_pend;
  logic [ADDR_BITS-1:0] r_addr, w_addr;
  logic                 r_rden, w_rden;
  logic [3:0]           r_io_out, w_io_out;
  logic                 r_cont_mode, w_cont_mode;
  logic [23:0]          w_in_1, w_in_4;

  assign w_in_1 = {r_in[22:0], w_io[0]};
  assign w_in_4 = {r_in[19:0], w_io};

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_in         <= '0;
      r_out        <= '0;
      r_prefetch   <= '0;
      r_fetch_pend <= 1'b0;
      r_addr       <= '0;
      r_rden       <= 1'b0;
      r_io_out     <= '0;
      r_cont_mode  <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_in         <= w_in;
      r_out        <= w_out;
      r_prefetch   <= w_prefetch;
      r_fetch_pend <= r_rden;
      r_addr       <= w_addr;
      r_rden       <= w_rden;
      r_io_out     <= w_io_out;
      r_cont_mode  <= w_cont_mode;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_in        = r_in;
    w_out       = r_out;
    w_addr      = r_addr;
    w_rden      = 1'b0;
    w_io_out    = r_io_out;
    w_cont_mode = r_cont_mode;
    w_prefetch  = r_fetch_pend ? i_mem_rdata : r_prefetch;

    // CS# release outranks any SCK edge seen in the same clock.
    if (w_cs_rise) begin
      w_state  = StIdle;
      w_cnt    = '0;
      w_io_out = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_io_out = '0;
          if (w_cs_fall) begin
            w_cnt   = '0;
            w_state = r_cont_mode ? StQaddr : StCmd;
          end
        end
        StCmd: if (w_sck_rise) begin
          w_in  = w_in_1;
          w_cnt = r_cnt + 5'd1;
          if (r_cnt == 5'd7) begin
            w_cnt = '0;
            case (w_in_1[7:0])
              CMD_READ:  w_state = StSaddr;
              CMD_QREAD: w_state = StQaddr;
              CMD_RDSR:  w_state = StStatus;
              default:   w_state = StIgnore;
            endcase
          end
        end
        StSaddr: if (w_sck_rise) begin
          w_in  = w_in_1;
          w_cnt = r_cnt + 5'd1;
          if (r_cnt == 5'd23) begin
            w_cnt   = '0;
            w_addr  = w_in_1[ADDR_BITS-1:0];
            w_rden  = 1'b1;
            w_state = StSdata;
          end
        end
        StQaddr: if (w_sck_rise) begin
          w_in  = w_in_4;
          w_cnt = r_cnt + 5'd1;
          if (r_cnt == 5'd5) begin
            w_cnt   = '0;
            w_addr  = w_in_4[ADDR_BITS-1:0];
            w_rden  = 1'b1;
            w_state = StQmode;
          end
        end
        StQmode: if (w_sck_rise) begin
          w_in  = w_in_4;
          w_cnt = r_cnt + 5'd1;
          if (r_cnt == 5'd1) begin
            w_cnt       = '0;
            w_cont_mode = (w_in_4[5:4] == CONT_PATTERN);
            w_state     = (QUAD_DUMMY == 0) ? StQdata : StQdummy;
          end
        end
        StQdummy: if (w_sck_rise) begin
          w_cnt = r_cnt + 5'd1;
          if (r_cnt == DUMMY_LAST) begin
            w_cnt   = '0;
            w_state = StQdata;
          end
        end
        StSdata: if (w_sck_fall) begin
          w_cnt = (r_cnt == 5'd7) ? 5'd0 : r_cnt + 5'd1;
          if (r_cnt == 5'd0) begin
            w_out    = {r_prefetch[6:0], 1'b0};
            w_io_out = {2'b00, r_prefetch[7], 1'b0};
            w_addr   = r_addr + 1'b1;
            w_rden   = 1'b1;
          end else begin
            w_out    = {r_out[6:0], 1'b0};
            w_io_out = {2'b00, r_out[7], 1'b0};
          end
        end
        StQdata: if (w_sck_fall) begin
          w_cnt = (r_cnt == 5'd0) ? 5'd1 : 5'd0;
          if (r_cnt == 5'd0) begin
            w_out    = {r_prefetch[3:0], 4'h0};
            w_io_out = r_prefetch[7:4];
            w_addr   = r_addr + 1'b1;
            w_rden   = 1'b1;
          end else begin
            w_io_out = r_out[7:4];
          end
        end
        StStatus: w_io_out = '0;
        StIgnore: w_io_out = '0;
        default:  w_state  = StIdle;
      endcase
    end
  end

  assign o_io_out   = r_io_out;
  assign o_io_oe    = oe_for_state(r_state);
  assign o_mem_rden = r_rden;
  assign o_mem_addr = r_addr;
  assign o_busy     = ~w_cs_n;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Bench for spi_flash_responder: drives a mode-0 SPI initiator and a sparse backing memory,
// queues expected data/fetch addresses at stimulus time and compares as the DUT responds.
module tb_spi_flash_responder;
  localparam int HALF   = 5;
  localparam int QDUMMY = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        cs_n = 1'b1;
  logic [3:0]  io_in = 4'h0;
  logic [3:0]  io_out, io_oe;
  logic        mem_rden;
  logic [23:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mem [logic [23:0]];
  logic [7:0]  exp_q[$];
  logic [23:0] exp_addr_q[$];
  logic [23:0] obs_addr_q[$];
  int          rden_run = 0;
  int          rden_max = 0;
  logic [3:0]  smp_out, smp_oe;

  always #5 clk = ~clk;

  spi_flash_responder #(
    .ADDR_BITS  (24),
    .QUAD_DUMMY (QDUMMY)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rst_n),
    .i_spi_sck   (sck),
    .i_spi_cs_n  (cs_n),
    .i_io_in     (io_in),
    .o_io_out    (io_out),
    .o_io_oe     (io_oe),
    .o_mem_rden  (mem_rden),
    .o_mem_addr  (mem_addr),
    .i_mem_rdata (mem_rdata),
    .o_busy      (busy)
  );

  always @(posedge clk) begin
    if (mem_rden) mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 8'h00;
  end

  // Fetch monitor: records every strobe address and the longest strobe run.
  always @(negedge clk) begin
    if (mem_rden) begin
      obs_addr_q.push_back(mem_addr);
      rden_run = rden_run + 1;
      if (rden_run > rden_max) rden_max = rden_run;
    end else begin
      rden_run = 0;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // One SCK period: drive, sample the DUT just before the rise, rise, then fall.
  task automatic sck_cycle(input logic [3:0] drv);
    io_in = drv;
    repeat (HALF) @(posedge clk);
    #1;
    smp_out = io_out;
    smp_oe  = io_oe;
    sck = 1'b1;
    repeat (HALF) @(posedge clk);
    #1;
    sck = 1'b0;
  endtask

  task automatic cs_low();
    @(posedge clk);
    #1;
    cs_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Raised in the same instant as the last SCK fall, so the CS# rise must win.
  task automatic cs_high();
    cs_n = 1'b1;
    sck  = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n, output logic [3:0] oe_or);
    oe_or = 4'h0;
    for (int i = n - 1; i >= 0; i--) begin
      sck_cycle({3'b000, v[i]});
      oe_or = oe_or | smp_oe;
    end
  endtask

  task automatic send_nibbles(input logic [31:0] v, input int n, output logic [3:0] oe_or);
    oe_or = 4'h0;
    for (int i = n - 1; i >= 0; i--) begin
      sck_cycle(v[4*i +: 4]);
      oe_or = oe_or | smp_oe;
    end
  endtask

  task automatic dummy_cycles(input int n, output logic [3:0] oe_or);
    oe_or = 4'h0;
    for (int i = 0; i < n; i++) begin
      sck_cycle(4'h0);
      oe_or = oe_or | smp_oe;
    end
  endtask

  // oe_seen is the common enable across the byte, or X if it varied.
  task automatic read_byte1(output logic [7:0] b, output logic [3:0] oe_seen);
    for (int i = 7; i >= 0; i--) begin
      sck_cycle(4'h0);
      b[i] = smp_out[1];
      if (i == 7) oe_seen = smp_oe;
      else if (smp_oe !== oe_seen) oe_seen = 4'bxxxx;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (io_oe !== 4'h0) begin n_errors++; $display("FAIL reset_oe: got %b want 0000", io_oe); end
    n_checks++;
    if (io_out !== 4'h0) begin n_errors++; $display("FAIL reset_out: got %b want 0000", io_out); end
    n_checks++;
    if (mem_rden !== 1'b0) begin n_errors++; $display("FAIL reset_rden: got %b want 0", mem_rden); end
    n_checks++;
    if (mem_addr !== 24'h0) begin n_errors++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if (dut.r_cont_mode !== 1'b0) begin
      n_errors++; $display("FAIL reset_cont: got %b want 0", dut.r_cont_mode);
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_single_read();
    logic [3:0] oe_or, oe_seen;
    logic [7:0] b, e;
    mem[24'h10] = 8'hA5; mem[24'h11] = 8'h3C; mem[24'h12] = 8'hFF;
    exp_q.delete();
    exp_q.push_back(8'hA5); exp_q.push_back(8'h3C); exp_q.push_back(8'hFF);
    // One lookahead fetch per byte boundary, beyond the initial address fetch.
    exp_addr_q = '{24'h10, 24'h11, 24'h12, 24'h13};
    obs_addr_q.delete();
    rden_max = 0;
    cs_low();
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL sread_busy: got %b want 1", busy); end
    send_bits(32'h0300_0010, 32, oe_or);
    n_checks++;
    if (oe_or !== 4'h0) begin n_errors++; $display("FAIL sread_oe_hdr: got %b want 0000", oe_or); end
    for (int k = 0; k < 3; k++) begin
      read_byte1(b, oe_seen);
      e = exp_q.pop_front();
      n_checks++;
      if (b !== e) begin n_errors++; $display("FAIL sread_data%0d: got %h want %h", k, b, e); end
      n_checks++;
      if (oe_seen !== 4'b0010) begin
        n_errors++; $display("FAIL sread_oe%0d: got %b want 0010", k, oe_seen);
      end
    end
    cs_high();
    n_checks++;
    if (io_oe !== 4'h0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL sread_end: got oe=%b busy=%b want 0000/0", io_oe, busy);
    end
    n_checks++;
    if (obs_addr_q.size() != exp_addr_q.size()) begin
      n_errors++;
      $display("FAIL sread_nfetch: got %0d want %0d", obs_addr_q.size(), exp_addr_q.size());
    end else begin
      foreach (exp_addr_q[k]) begin
        n_checks++;
        if (obs_addr_q[k] !== exp_addr_q[k]) begin
          n_errors++; $display("FAIL sread_fetch%0d: got %h want %h", k, obs_addr_q[k], exp_addr_q[k]);
        end
      end
    end
    n_checks++;
    if (rden_max != 1) begin n_errors++; $display("FAIL rden_width: got %0d want 1", rden_max); end
  endtask

  // Quad read of nbytes from addr with the given mode byte; starts with 0xEB unless with_cmd=0.
  task automatic quad_xfer(input bit with_cmd, input logic [23:0] addr, input logic [7:0] mode,
                           input int nbytes, input string tag);
    logic [3:0] oe_a, oe_b, oe_c, oe_d, oe_seen;
    logic [7:0] e;
    cs_low();
    oe_a = 4'h0;
    if (with_cmd) send_bits(32'hEB, 8, oe_a);
    send_nibbles({8'h00, addr}, 6, oe_b);
    send_nibbles({24'h0, mode}, 2, oe_c);
    dummy_cycles(QDUMMY, oe_d);
    n_checks++;
    if ((oe_a | oe_b | oe_c | oe_d) !== 4'h0) begin
      n_errors++; $display("FAIL %s_oe_hdr: got %b want 0000", tag, oe_a | oe_b | oe_c | oe_d);
    end
    for (int k = 0; k < 2 * nbytes; k++) begin
      sck_cycle(4'h0);
      e = exp_q.pop_front();
      n_checks++;
      if ({4'h0, smp_out} !== e) begin
        n_errors++; $display("FAIL %s_nib%0d: got %h want %h", tag, k, smp_out, e[3:0]);
      end
      if (k == 0) oe_seen = smp_oe;
      else if (smp_oe !== oe_seen) oe_seen = 4'bxxxx;
    end
    n_checks++;
    if (oe_seen !== 4'b1111) begin n_errors++; $display("FAIL %s_oe: got %b want 1111", tag, oe_seen); end
    cs_high();
  endtask

  task automatic test_quad_read();
    mem[24'h100000] = 8'h12; mem[24'h100001] = 8'h34;
    exp_q.delete();
    for (int k = 1; k <= 4; k++) exp_q.push_back(8'(k));
    exp_addr_q = '{24'h100000, 24'h100001, 24'h100002};
    obs_addr_q.delete();
    quad_xfer(1'b1, 24'h100000, 8'h00, 2, "quad");
    n_checks++;
    if (dut.r_cont_mode !== 1'b0) begin
      n_errors++; $display("FAIL quad_cont: got %b want 0", dut.r_cont_mode);
    end
    n_checks++;
    if (obs_addr_q.size() != 3 || obs_addr_q[0] !== exp_addr_q[0] || obs_addr_q[1] !== exp_addr_q[1]
        || obs_addr_q[2] !== exp_addr_q[2]) begin
      n_errors++; $display("FAIL quad_fetch: got %p want %p", obs_addr_q, exp_addr_q);
    end
  endtask

  task automatic test_continuous();
    mem[24'h200] = 8'h9E; mem[24'h100] = 8'h5A; mem[24'h101] = 8'hC3;
    exp_q.delete();
    exp_q.push_back(8'h9); exp_q.push_back(8'hE);
    quad_xfer(1'b1, 24'h000200, 8'hA0, 1, "cont1");
    n_checks++;
    if (dut.r_cont_mode !== 1'b1) begin
      n_errors++; $display("FAIL cont1_mode: got %b want 1", dut.r_cont_mode);
    end
    exp_q.push_back(8'h5); exp_q.push_back(8'hA); exp_q.push_back(8'hC); exp_q.push_back(8'h3);
    obs_addr_q.delete();
    quad_xfer(1'b0, 24'h000100, 8'hA0, 2, "cont2");
    n_checks++;
    if (obs_addr_q.size() == 0 || obs_addr_q[0] !== 24'h000100) begin
      n_errors++; $display("FAIL cont2_fetch: got %p want first 000100", obs_addr_q);
    end
    exp_q.push_back(8'h5); exp_q.push_back(8'hA);
    quad_xfer(1'b0, 24'h000100, 8'hFF, 1, "cont3");
    n_checks++;
    if (dut.r_cont_mode !== 1'b0) begin
      n_errors++; $display("FAIL cont3_mode: got %b want 0", dut.r_cont_mode);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] oe_or, oe_seen;
    logic [7:0] b, e;
    mem[24'hFFFFFF] = 8'h77; mem[24'h000000] = 8'h88;
    exp_q.delete();
    exp_q.push_back(8'h77); exp_q.push_back(8'h88);
    exp_addr_q = '{24'hFFFFFF, 24'h000000, 24'h000001};
    obs_addr_q.delete();
    cs_low();
    send_bits(32'h03FF_FFFF, 32, oe_or);
    for (int k = 0; k < 2; k++) begin
      read_byte1(b, oe_seen);
      e = exp_q.pop_front();
      n_checks++;
      if (b !== e) begin n_errors++; $display("FAIL wrap_data%0d: got %h want %h", k, b, e); end
    end
    cs_high();
    n_checks++;
    if (obs_addr_q.size() != 3 || obs_addr_q[0] !== exp_addr_q[0] || obs_addr_q[1] !== exp_addr_q[1]
        || obs_addr_q[2] !== exp_addr_q[2]) begin
      n_errors++; $display("FAIL wrap_fetch: got %p want %p", obs_addr_q, exp_addr_q);
    end
  endtask

  task automatic test_abort_status();
    logic [3:0] oe_or, oe_seen;
    logic [7:0] b;
    obs_addr_q.delete();
    cs_low();
    send_bits({12'h0, 8'h03, 12'h123}, 20, oe_or);
    cs_high();
    n_checks++;
    if (obs_addr_q.size() != 0 || io_oe !== 4'h0) begin
      n_errors++; $display("FAIL abort: got fetches=%0d oe=%b want 0/0000", obs_addr_q.size(), io_oe);
    end
    cs_low();
    send_bits(32'h05, 8, oe_or);
    read_byte1(b, oe_seen);
    n_checks++;
    if (b !== 8'h00) begin n_errors++; $display("FAIL status_data: got %h want 00", b); end
    n_checks++;
    if (oe_seen !== 4'b0010) begin n_errors++; $display("FAIL status_oe: got %b want 0010", oe_seen); end
    cs_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (io_oe !== 4'b0010) begin n_errors++; $display("FAIL status_oe_hold: got %b want 0010", io_oe); end
    @(posedge clk);
    #1;
    n_checks++;
    if (io_oe !== 4'h0) begin n_errors++; $display("FAIL status_oe_drop: got %b want 0000", io_oe); end
    cs_high();
    obs_addr_q.delete();
    cs_low();
    send_bits(32'h9F, 8, oe_or);
    dummy_cycles(16, oe_seen);
    cs_high();
    n_checks++;
    if ((oe_or | oe_seen) !== 4'h0 || obs_addr_q.size() != 0) begin
      n_errors++;
      $display("FAIL ignore: got oe=%b fetches=%0d want 0000/0", oe_or | oe_seen, obs_addr_q.size());
    end
  endtask

  task automatic test_reset_mid_qdata();
    logic [3:0] oe_a, oe_b, oe_c, oe_d, oe_seen;
    logic [7:0] b;
    mem[24'h300] = 8'hC7;
    cs_low();
    send_bits(32'hEB, 8, oe_a);
    send_nibbles(32'h000300, 6, oe_b);
    send_nibbles(32'hA0, 2, oe_c);
    dummy_cycles(QDUMMY, oe_d);
    sck_cycle(4'h0);
    n_checks++;
    if (smp_out !== 4'hC) begin n_errors++; $display("FAIL rst_pre_nib: got %h want c", smp_out); end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (io_out !== 4'h7 || io_oe !== 4'hF || dut.r_cont_mode !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_pre_state: got out=%h oe=%b cont=%b want 7/1111/1", io_out, io_oe,
               dut.r_cont_mode);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (io_out !== 4'h0 || io_oe !== 4'h0 || mem_rden !== 1'b0 || mem_addr !== 24'h0
        || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_outputs: got out=%h oe=%b rden=%b addr=%h busy=%b want all 0", io_out,
               io_oe, mem_rden, mem_addr, busy);
    end
    n_checks++;
    if (dut.r_cont_mode !== 1'b0) begin
      n_errors++; $display("FAIL rst_cont: got %b want 0", dut.r_cont_mode);
    end
    cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    exp_q.delete();
    exp_q.push_back(8'hFF);
    cs_low();
    send_bits(32'h0300_0012, 32, oe_a);
    read_byte1(b, oe_seen);
    cs_high();
    n_checks++;
    if (b !== exp_q[0]) begin n_errors++; $display("FAIL rst_next_cmd: got %h want %h", b, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_quad_read();
    test_continuous();
    test_wrap();
    test_abort_status();
    test_reset_mid_qdata();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
